execute_unit: RTL and testbench
===============================

# execute_unit

Execute stage of the 8-bit multi-cycle CPU, downstream of the fetch/decode sequencer. Latches the instruction byte from ROM when the sequencer pulses `ir_load`, then steps through a per-opcode micro-sequence over a 4×8 register file and an accumulator. It reports progress on `cu_state` and signals completion with `3'b111` (DONE), which releases the sequencer back to FETCH.

## Interface
- `DATA_W`, 8: accumulator/register width; must be ≥ 5 (LDI immediate).
- `clk  in  1`: single clock, rising edge.
- `reset  in  1`: asynchronous, active-low (0 = reset).
- `ir_load  in  1`: one-cycle pulse from sequencer; latch `instr` on this edge.
- `instr  in  8`: ROM data byte.
- `cu_state  out  3`: current micro-step; 3'b111 = DONE.
- `acc  out  DATA_W`: accumulator.
- `carry  out  1`: carry/borrow/shift-out flag.
- `zero  out  1`: acc == 0 after last ALU/LDI/SHL write.
- `halted  out  1`: HALT executed.

## Operation
- Fields: opcode `instr[7:5]`, rd `[4:3]`, rs `[1:0]`, imm `[4:0]` (zero-extended), count `[2:0]`.
- `cu_state` encodings: IDLE 000, READ 001, ALU 010, WB 011, SHIFT 100, STORE 101, HALT 110, DONE 111.
- Opcode sequences (first state entered on the latching edge):
  - 000 NOP: DONE.
  - 001 LDI: WB (acc←imm, zero updated, carry←0) → DONE.
  - 010 ADD / 011 SUB / 100 AND: READ (opnd←reg[rs]) → ALU (res←acc op opnd) → WB (acc←res, flags) → DONE.
  - 101 STA: STORE (reg[rd]←acc) → DONE; flags unchanged.
  - 110 SHL: count SHIFT cycles, each acc←acc<<1, carry←old acc[DATA_W-1], zero updated; count 0 → DONE directly, flags unchanged.
  - 111 HALT: HALT, `halted`=1; stays until reset, never reaches DONE.
- DONE lasts exactly one cycle, then IDLE.
- Arithmetic mod 2^DATA_W. ADD carry = carry-out. SUB carry = borrow (acc < opnd). AND carry ← 0.
- `ir_load` is accepted only in IDLE or DONE; in any other state it is ignored and `ir` is not modified. In DONE it is accepted and takes precedence over the return to IDLE.

## Timing
- Reset: `cu_state`=IDLE, `acc`=0, `carry`=0, `zero`=1, `halted`=0, all registers and `ir`=0. Reset asserted mid-sequence aborts immediately with no partial writeback.
- Latency from the `ir_load` edge to the first cycle showing DONE: NOP 1, LDI 2, STA 2, ADD/SUB/AND 4, SHL count+1 (1–8).
- Register writes take effect at the end of their step. An ADD that follows an STA to the same register reads the new value.
- The sequencer samples `cu_state` each clock edge. On the edge that leaves DONE, the sequencer advances its program counter and refetches. The next `ir_load` arrives at least 2 cycles later.

## Structure
- Shared package `cpu_pkg`: opcode constants, `cu_state` encodings (shared with the sequencer's DONE compare), `DATA_W`.
- Sub-module `alu`: combinational; inputs `a`, `b`, `op` (ADD/SUB/AND); outputs `y`, `carry`. The parent owns all registers.

## Test plan
- Reset check: hold `reset`=0, then release → `cu_state`=000, `acc`=0, `zero`=1, `halted`=0. Assert reset during an ADD's ALU step → all outputs return to reset values and `acc` is unchanged by the aborted ADD.
- Load, store and add: LDI 0x1F (0x3F); STA r2 (0xB0); LDI 0x05 (0x25); ADD r2 (0x42):
  - `acc`=0x24, `carry`=0, `zero`=0.
  - DONE appears 4 cycles after the ADD `ir_load`.
- Subtract with borrow and AND: acc=0x05, r2=0x1F; SUB r2 → `acc`=0xE6, `carry`=1. Then AND r2 → `acc`=0x06, `carry`=0.
- Shift: acc=0x81; SHL 3 (0xC3) → `acc`=0x08, `carry`=0, DONE after 4 cycles. SHL 0 → DONE after 1 cycle, `acc` and flags unchanged.
- HALT and stray pulses:
  - 0xE0 → `cu_state`=110, `halted`=1 for 20+ cycles; further `ir_load` pulses are ignored.
  - `ir_load` pulsed during an ADD's READ step → sequence completes unchanged and `ir` is unmodified.
- Closed loop with the sequencer: program of 8 mixed instructions → each DONE is exactly one cycle wide, the program counter steps 0..7, and final `acc` matches the reference model.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit multi-cycle CPU: widths, opcodes, micro-step
// encodings and the instruction-byte layout.
package cpu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned INSTR_W = 8;
  localparam int unsigned REG_N   = 4;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned IMM_W   = 5;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LDI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_STA  = 3'b101,
    OP_SHL  = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  // Encodings are also compared by the sequencer, so they must stay fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_READ  = 3'b001,
    ST_ALU   = 3'b010,
    ST_WB    = 3'b011,
    ST_SHIFT = 3'b100,
    ST_STORE = 3'b101,
    ST_HALT  = 3'b110,
    ST_DONE  = 3'b111
  } cu_state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10
  } alu_op_e;

  typedef struct packed {
    opcode_e    opcode;
    logic [1:0] rd;
    logic       mid;
    logic [1:0] rs;
  } instr_t;

  function automatic logic [IMM_W-1:0] instr_imm(input instr_t i);
    return {i.rd, i.mid, i.rs};
  endfunction

  function automatic logic [CNT_W-1:0] instr_count(input instr_t i);
    return {i.mid, i.rs};
  endfunction

  function automatic alu_op_e alu_op_of(input opcode_e op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: add with carry-out, subtract with borrow, bitwise AND.
module alu #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
  input  logic [DATA_W-1:0]      a,
  input  logic [DATA_W-1:0]      b,
  input  cpu_pkg::alu_op_e       op,
  output logic [DATA_W-1:0]      y,
  output logic                   carry
);
  import cpu_pkg::*;

  logic [DATA_W:0] wide;

  // The extra top bit is carry-out for ADD and borrow (a < b) for SUB.
  always_comb begin
    wide  = '0;
    y     = '0;
    carry = 1'b0;
    case (op)
      ALU_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        y     = wide[DATA_W-1:0];
        carry = wide[DATA_W];
      end
      ALU_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        y     = wide[DATA_W-1:0];
        carry = wide[DATA_W];
      end
      ALU_AND: y = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: latches an instruction byte on ir_load and runs its micro-sequence
// over a 4-entry register file and accumulator, signalling DONE for one cycle.
module execute_unit #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ir_load,
  input  logic [cpu_pkg::INSTR_W-1:0] instr,
  output logic [2:0]                  cu_state,
  output logic [DATA_W-1:0]           acc,
  output logic                        carry,
  output logic                        zero,
  output logic                        halted
);
  import cpu_pkg::*;

  cu_state_e         state_q, state_d;
  instr_t            ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              res_carry_q, res_carry_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] regs_d [REG_N];

  logic [DATA_W-1:0] alu_y;
  logic              alu_carry;
  logic              accept_c;
  instr_t            new_ir_c;

  alu #(.DATA_W(DATA_W)) u_alu (
    .a     (acc_q),
    .b     (opnd_q),
    .op    (alu_op_of(ir_q.opcode)),
    .y     (alu_y),
    .carry (alu_carry)
  );

  assign new_ir_c = instr_t'(instr);
  assign accept_c = ir_load && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Next-state and datapath: each step commits its write on the edge that leaves it.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    res_d       = res_q;
    res_carry_d = res_carry_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    halted_d    = halted_q;
    cnt_d       = cnt_q;
    regs_d      = regs_q;

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_READ: begin
        opnd_d  = regs_q[ir_q.rs];
        state_d = ST_ALU;
      end
      ST_ALU: begin
        res_d       = alu_y;
        res_carry_d = alu_carry;
        state_d     = ST_WB;
      end
      ST_WB: begin
        if (ir_q.opcode == OP_LDI) begin
          acc_d   = DATA_W'(instr_imm(ir_q));
          carry_d = 1'b0;
        end else begin
          acc_d   = res_q;
          carry_d = res_carry_q;
        end
        zero_d  = (acc_d == '0);
        state_d = ST_DONE;
      end
      ST_STORE: begin
        regs_d[ir_q.rd] = acc_q;
        state_d         = ST_DONE;
      end
      ST_SHIFT: begin
        acc_d   = {acc_q[DATA_W-2:0], 1'b0};
        carry_d = acc_q[DATA_W-1];
        zero_d  = (acc_d == '0);
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_HALT: state_d = ST_HALT;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A new instruction in DONE overrides the return to IDLE.
    if (accept_c) begin
      ir_d  = new_ir_c;
      cnt_d = instr_count(new_ir_c);
      case (new_ir_c.opcode)
        OP_NOP:  state_d = ST_DONE;
        OP_LDI:  state_d = ST_WB;
        OP_ADD,
        OP_SUB,
        OP_AND:  state_d = ST_READ;
        OP_STA:  state_d = ST_STORE;
        OP_SHL:  state_d = (instr_count(new_ir_c) == '0) ? ST_DONE : ST_SHIFT;
        OP_HALT: begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end
        default: state_d = ST_DONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      res_q       <= '0;
      res_carry_q <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
      halted_q    <= 1'b0;
      cnt_q       <= '0;
      regs_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      res_q       <= res_d;
      res_carry_q <= res_carry_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
      regs_q      <= regs_d;
    end
  end

  assign cu_state = state_q;
  assign acc      = acc_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit with hand-computed expectations and a simple
// sequencer model for the closed-loop program.
module tb_execute_unit;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       ir_load = 1'b0;
  logic [7:0] instr   = 8'h00;
  logic [2:0] cu_state;
  logic [7:0] acc;
  logic       carry;
  logic       zero;
  logic       halted;

  int errors = 0;
  int checks = 0;

  logic [7:0] prog    [8] = '{8'h27, 8'hB8, 8'hC2, 8'h43, 8'h63, 8'hA8, 8'hC7, 8'h41};
  int         exp_lat [8] = '{2, 2, 3, 4, 4, 2, 8, 4};

  execute_unit dut (
    .clk      (clk),
    .reset    (reset),
    .ir_load  (ir_load),
    .instr    (instr),
    .cu_state (cu_state),
    .acc      (acc),
    .carry    (carry),
    .zero     (zero),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse one instruction, return cycles to DONE, then confirm DONE lasted one cycle.
  task automatic exec(input logic [7:0] ins, output int lat);
    ir_load = 1'b1;
    instr   = ins;
    tick();
    ir_load = 1'b0;
    lat     = 1;
    while (cu_state != 3'b111 && lat < 40) begin
      tick();
      lat++;
    end
    tick();
    chk("done_one_cycle", 16'(cu_state), 16'h0);
  endtask

  initial begin
    int lat;
    int pc;
    int not_halt;

    #2 reset = 1'b0;
    repeat (3) tick();
    chk("rst_state", 16'(cu_state), 16'h0);
    chk("rst_acc", 16'(acc), 16'h0);
    chk("rst_carry", 16'(carry), 16'h0);
    chk("rst_zero", 16'(zero), 16'h1);
    chk("rst_halted", 16'(halted), 16'h0);
    reset = 1'b1;
    tick();
    chk("idle_after_release", 16'(cu_state), 16'h0);

    // NOP followed back-to-back by LDI accepted while in DONE
    ir_load = 1'b1;
    instr   = 8'h00;
    tick();
    chk("nop_done", 16'(cu_state), 16'h7);
    instr = 8'h2A;
    tick();
    ir_load = 1'b0;
    chk("load_in_done_wb", 16'(cu_state), 16'h3);
    tick();
    chk("ldi_after_done", 16'(cu_state), 16'h7);
    chk("ldi_0a_acc", 16'(acc), 16'h0A);
    tick();
    chk("idle_after_ldi", 16'(cu_state), 16'h0);

    // Load, store, add
    exec(8'h3F, lat);
    chk("ldi_lat", 16'(lat), 16'd2);
    chk("ldi_1f_acc", 16'(acc), 16'h1F);
    chk("ldi_1f_zero", 16'(zero), 16'h0);
    exec(8'hB0, lat);
    chk("sta_lat", 16'(lat), 16'd2);
    chk("sta_r2", 16'(dut.regs_q[2]), 16'h1F);
    exec(8'h25, lat);
    exec(8'h42, lat);
    chk("add_lat", 16'(lat), 16'd4);
    chk("add_acc", 16'(acc), 16'h24);
    chk("add_carry", 16'(carry), 16'h0);
    chk("add_zero", 16'(zero), 16'h0);

    // Subtract with borrow, then AND
    exec(8'h25, lat);
    exec(8'h62, lat);
    chk("sub_lat", 16'(lat), 16'd4);
    chk("sub_acc", 16'(acc), 16'hE6);
    chk("sub_borrow", 16'(carry), 16'h1);
    exec(8'h82, lat);
    chk("and_acc", 16'(acc), 16'h06);
    chk("and_carry", 16'(carry), 16'h0);

    // Build acc = 0x81 then shift
    exec(8'h30, lat);
    exec(8'hC3, lat);
    chk("shl_build_acc", 16'(acc), 16'h80);
    exec(8'hA8, lat);
    exec(8'h21, lat);
    exec(8'h41, lat);
    chk("acc_81", 16'(acc), 16'h81);
    exec(8'hC3, lat);
    chk("shl3_lat", 16'(lat), 16'd4);
    chk("shl3_acc", 16'(acc), 16'h08);
    chk("shl3_carry", 16'(carry), 16'h0);
    exec(8'hC5, lat);
    chk("shl5_lat", 16'(lat), 16'd6);
    chk("shl5_acc", 16'(acc), 16'h00);
    chk("shl5_carry", 16'(carry), 16'h1);
    chk("shl5_zero", 16'(zero), 16'h1);
    exec(8'hC0, lat);
    chk("shl0_lat", 16'(lat), 16'd1);
    chk("shl0_acc", 16'(acc), 16'h00);
    chk("shl0_carry", 16'(carry), 16'h1);
    chk("shl0_zero", 16'(zero), 16'h1);

    // Stray ir_load during READ must be ignored
    exec(8'h22, lat);
    ir_load = 1'b1;
    instr   = 8'h42;
    tick();
    chk("stray_read", 16'(cu_state), 16'h1);
    instr = 8'hE0;
    tick();
    ir_load = 1'b0;
    chk("stray_alu", 16'(cu_state), 16'h2);
    chk("stray_ir", 16'(dut.ir_q), 16'h42);
    tick();
    chk("stray_wb", 16'(cu_state), 16'h3);
    tick();
    chk("stray_done", 16'(cu_state), 16'h7);
    chk("stray_acc", 16'(acc), 16'h21);
    chk("stray_halted", 16'(halted), 16'h0);
    tick();

    // Reset during ADD's ALU step aborts without writeback
    ir_load = 1'b1;
    instr   = 8'h42;
    tick();
    ir_load = 1'b0;
    tick();
    chk("abort_at_alu", 16'(cu_state), 16'h2);
    #2 reset = 1'b0;
    #1;
    chk("abort_state", 16'(cu_state), 16'h0);
    chk("abort_acc", 16'(acc), 16'h0);
    chk("abort_carry", 16'(carry), 16'h0);
    chk("abort_zero", 16'(zero), 16'h1);
    chk("abort_r2", 16'(dut.regs_q[2]), 16'h0);
    tick();
    reset = 1'b1;
    tick();

    // Closed loop: sequencer advances pc on the edge leaving DONE
    pc = 0;
    for (int i = 0; i < 8; i++) begin
      exec(prog[pc], lat);
      chk("loop_lat", 16'(lat), 16'(exp_lat[i]));
      pc++;
      tick();
    end
    chk("loop_pc", 16'(pc), 16'd8);
    chk("loop_acc", 16'(acc), 16'h1C);
    chk("loop_carry", 16'(carry), 16'h0);
    chk("loop_zero", 16'(zero), 16'h0);

    // HALT holds through stray pulses
    ir_load = 1'b1;
    instr   = 8'hE0;
    tick();
    ir_load = 1'b0;
    chk("halt_state", 16'(cu_state), 16'h6);
    chk("halt_flag", 16'(halted), 16'h1);
    not_halt = 0;
    for (int i = 0; i < 24; i++) begin
      ir_load = (i % 4 == 0);
      instr   = 8'h25;
      tick();
      if (cu_state != 3'b110 || halted != 1'b1) not_halt++;
    end
    ir_load = 1'b0;
    chk("halt_hold", 16'(not_halt), 16'd0);
    chk("halt_acc", 16'(acc), 16'h1C);
    chk("halt_ir", 16'(dut.ir_q), 16'hE0);
    reset = 1'b0;
    #2;
    chk("halt_reset_state", 16'(cu_state), 16'h0);
    chk("halt_reset_flag", 16'(halted), 16'h0);
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
